hazard_stall_control: RTL and testbench
=======================================

Name: hazard_stall_control

Overview:
- Consumer-side companion to the bypass selector in the 5-stage pipeline.
- Detects hazards that forwarding cannot cover and freezes or bubbles pipeline stages:
  - load-use on the instruction in FD;
  - multi-cycle mul/div occupancy in DX.
- Sequences the mul/div unit handshake: start pulse, busy wait, result capture, timeout.

Parameters:
- MD_TIMEOUT, 40, max BUSY cycles before forced completion.
- CNT_W, 6, width of BUSY cycle counter; must hold MD_TIMEOUT.
- STAT_W, 16, width of stall statistics counters (optional feature only).

Ports:
- clock  in  1  pipeline clock, rising edge.
- reset  in  1  asynchronous active-low reset.
- rs_fd, rt_fd, rd_fd  in  5 each  register fields of instruction in FD.
- fd_uses_rs, fd_uses_rt, fd_uses_rd  in  1 each  FD instruction reads that field.
  - sw and bne/blt read rd.
- fd_is_bex  in  1  FD instruction reads r30.
- rd_dx  in  5  destination field of DX instruction.
- dx_is_lw, dx_is_mul, dx_is_div  in  1 each  DX instruction class.
- md_ready  in  1  mul/div unit result ready (level).
- md_exception  in  1  mul/div unit exception, sampled with md_ready.
- stall_pc, stall_fd, stall_dx  out  1 each  hold enables for PC, FD, DX latches.
- bubble_dx  out  1  insert nop into DX at the next edge.
- bubble_xm  out  1  insert nop into XM at the next edge.
- ctrl_MULT, ctrl_DIV  out  1 each  one-cycle start pulses to the mul/div unit.
- md_capture  out  1  XM latches the mul/div result at the next edge.
- md_exc_out  out  1  exception flag to XM, valid with md_capture.
- md_timeout  out  1  completion forced by timeout, valid with md_capture.

Behaviour:
- State machine: IDLE, BUSY, DONE. Single registered state plus a CNT_W counter; all outputs combinational from state and inputs.
- Reset (asynchronous, any time including mid-BUSY): state goes to IDLE, counter to 0. All outputs evaluate to 0 while reset is low.
- IDLE:
  - Load-use occurs when dx_is_lw, rd_dx != 0, and any of the following match:
    - fd_uses_rs with rs_fd == rd_dx;
    - fd_uses_rt with rt_fd == rd_dx;
    - fd_uses_rd with rd_fd == rd_dx;
    - fd_is_bex with rd_dx == 30.
  - On load-use: stall_pc = stall_fd = bubble_dx = 1 for exactly that cycle. No extra cycles; next cycle the lw is in XM and the bypass covers it.
  - If dx_is_mul or dx_is_div: pulse ctrl_MULT or ctrl_DIV respectively. Assert stall_pc, stall_fd, stall_dx and bubble_xm; counter to 0; next state BUSY.
  - Mul/div start has priority over load-use. A lw cannot be in DX with mul at the same time, so this is a tie-break rule only.
  - If both dx_is_mul and dx_is_div are set: ctrl_MULT wins, ctrl_DIV stays 0.
- BUSY:
  - stall_pc, stall_fd, stall_dx, bubble_xm all 1. No start pulses. Load-use detection masked.
  - Counter increments each cycle.
  - md_ready=1: next state DONE, latch md_exception.
  - Else counter == MD_TIMEOUT-1: next state DONE with timeout flag set.
  - md_ready and timeout in the same cycle: ready wins, timeout flag 0.
- DONE (exactly one cycle):
  - md_capture = 1; md_exc_out and md_timeout from the latched flags; all stalls and bubbles 0.
  - The mul/div instruction advances to XM at the end of this cycle.
  - No new start in DONE even if dx_is_mul is still high.
  - Next state IDLE; flags clear on exit.
- md_ready seen in IDLE or DONE is ignored.
- A register-0 destination never creates a load-use stall.

Optional Feature:
- Macro HAZARD_STALL_STATS_EN.
- When defined, adds outputs loaduse_cnt [STAT_W] and mdbusy_cnt [STAT_W]:
  - loaduse_cnt counts cycles with a load-use stall;
  - mdbusy_cnt counts BUSY cycles;
  - both saturate at all-ones and clear on reset.
- When undefined, these ports and registers do not exist; all other behaviour is identical.

Test Plan:
- lw r5 in DX, FD add reads rs=5 → stall_pc, stall_fd, bubble_dx high for 1 cycle only. Same with rd_dx=0 → no stall.
- lw r30 in DX, FD bex → 1-cycle stall. lw r4 in DX, FD sw with rd=4 and fd_uses_rd → 1-cycle stall.
- mul in DX, md_ready after 5 BUSY cycles → ctrl_MULT 1 cycle, 5 stall cycles, then md_capture=1 with md_timeout=0 and md_exc_out equal to md_exception, then IDLE.
- div with md_ready never asserted, MD_TIMEOUT=40 → exactly 40 BUSY cycles, then md_capture=1 with md_timeout=1.
- md_ready on the same cycle the counter hits MD_TIMEOUT-1 → md_timeout=0. Reset low mid-BUSY → all outputs 0 immediately, IDLE after release.
- With HAZARD_STALL_STATS_EN: 3 load-use stalls plus one 7-cycle BUSY → loaduse_cnt=3, mdbusy_cnt=7.

Source files
------------

// File: rtl/hazard_stall_control.sv
// Load-use and mul/div occupancy hazard control for the 5-stage pipeline; sequences the mul/div handshake.
// Optional stall statistics outputs are enabled by defining HAZARD_STALL_STATS_EN.
module hazard_stall_control #(
  parameter int unsigned MD_TIMEOUT = 40,
  parameter int unsigned CNT_W      = 6,
  parameter int unsigned STAT_W     = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [4:0] rs_fd,
  input  logic [4:0] rt_fd,
  input  logic [4:0] rd_fd,
  input  logic       fd_uses_rs,
  input  logic       fd_uses_rt,
  input  logic       fd_uses_rd,
  input  logic       fd_is_bex,
  input  logic [4:0] rd_dx,
  input  logic       dx_is_lw,
  input  logic       dx_is_mul,
  input  logic       dx_is_div,
  input  logic       md_ready,
  input  logic       md_exception,
  output logic       stall_pc,
  output logic       stall_fd,
  output logic       stall_dx,
  output logic       bubble_dx,
  output logic       bubble_xm,
  output logic       ctrl_MULT,
  output logic       ctrl_DIV,
  output logic       md_capture,
  output logic       md_exc_out,
  output logic       md_timeout
`ifdef HAZARD_STALL_STATS_EN
  ,
  output logic [STAT_W-1:0] loaduse_cnt,
  output logic [STAT_W-1:0] mdbusy_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } stateT;

  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(MD_TIMEOUT - 1);

  stateT            state, stateNext;
  logic [CNT_W-1:0] busyCnt, busyCntNext;
  logic             excFlag, excFlagNext;
  logic             toFlag, toFlagNext;
  logic             loadUse;
  logic             mdStart;
  logic             loadUseStall;

  assign loadUse = dx_is_lw && (rd_dx != '0) &&
                   ((fd_uses_rs && (rs_fd == rd_dx)) ||
                    (fd_uses_rt && (rt_fd == rd_dx)) ||
                    (fd_uses_rd && (rd_fd == rd_dx)) ||
                    (fd_is_bex  && (rd_dx == 5'd30)));

  assign mdStart = dx_is_mul || dx_is_div;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      busyCnt <= '0;
      excFlag <= 1'b0;
      toFlag  <= 1'b0;
    end else begin
      state   <= stateNext;
      busyCnt <= busyCntNext;
      excFlag <= excFlagNext;
      toFlag  <= toFlagNext;
    end
  end

  // Outputs stay at their zero defaults while reset is held low.
  always_comb begin
    stateNext    = state;
    busyCntNext  = busyCnt;
    excFlagNext  = excFlag;
    toFlagNext   = toFlag;
    stall_pc     = 1'b0;
    stall_fd     = 1'b0;
    stall_dx     = 1'b0;
    bubble_dx    = 1'b0;
    bubble_xm    = 1'b0;
    ctrl_MULT    = 1'b0;
    ctrl_DIV     = 1'b0;
    md_capture   = 1'b0;
    md_exc_out   = 1'b0;
    md_timeout   = 1'b0;
    loadUseStall = 1'b0;
    if (reset) begin
      unique case (state)
        IDLE: begin
          excFlagNext = 1'b0;
          toFlagNext  = 1'b0;
          if (mdStart) begin
            ctrl_MULT   = dx_is_mul;
            ctrl_DIV    = dx_is_div && !dx_is_mul;
            stall_pc    = 1'b1;
            stall_fd    = 1'b1;
            stall_dx    = 1'b1;
            bubble_xm   = 1'b1;
            busyCntNext = '0;
            stateNext   = BUSY;
          end else if (loadUse) begin
            stall_pc     = 1'b1;
            stall_fd     = 1'b1;
            bubble_dx    = 1'b1;
            loadUseStall = 1'b1;
          end
        end
        BUSY: begin
          stall_pc    = 1'b1;
          stall_fd    = 1'b1;
          stall_dx    = 1'b1;
          bubble_xm   = 1'b1;
          busyCntNext = busyCnt + CNT_W'(1);
          if (md_ready) begin
            excFlagNext = md_exception;
            toFlagNext  = 1'b0;
            stateNext   = DONE;
          end else if (busyCnt == TIMEOUT_LAST) begin
            excFlagNext = 1'b0;
            toFlagNext  = 1'b1;
            stateNext   = DONE;
          end
        end
        DONE: begin
          md_capture  = 1'b1;
          md_exc_out  = excFlag;
          md_timeout  = toFlag;
          excFlagNext = 1'b0;
          toFlagNext  = 1'b0;
          busyCntNext = '0;
          stateNext   = IDLE;
        end
        default: begin
          stateNext = IDLE;
        end
      endcase
    end
  end

`ifdef HAZARD_STALL_STATS_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      loaduse_cnt <= '0;
      mdbusy_cnt  <= '0;
    end else begin
      if (loadUseStall && (loaduse_cnt != '1)) loaduse_cnt <= loaduse_cnt + STAT_W'(1);
      if ((state == BUSY) && (mdbusy_cnt != '1)) mdbusy_cnt <= mdbusy_cnt + STAT_W'(1);
    end
  end
`else
  localparam int unsigned unusedStatW = STAT_W;
  logic unusedLoadUseStall;
  assign unusedLoadUseStall = loadUseStall;
`endif

endmodule

// File: tb/tb_hazard_stall_control.sv
// Directed self-checking bench for hazard_stall_control (default parameters).
// Stats checks are compiled in when HAZARD_STALL_STATS_EN is defined.
module tb_hazard_stall_control;

  logic       clock;
  logic       reset;
  logic [4:0] rs_fd, rt_fd, rd_fd, rd_dx;
  logic       fd_uses_rs, fd_uses_rt, fd_uses_rd, fd_is_bex;
  logic       dx_is_lw, dx_is_mul, dx_is_div;
  logic       md_ready, md_exception;
  logic       stall_pc, stall_fd, stall_dx, bubble_dx, bubble_xm;
  logic       ctrl_MULT, ctrl_DIV, md_capture, md_exc_out, md_timeout;
`ifdef HAZARD_STALL_STATS_EN
  logic [15:0] loaduse_cnt, mdbusy_cnt;
`endif

  int unsigned errors = 0;
  int unsigned checks = 0;

  // {stall_pc, stall_fd, stall_dx, bubble_dx, bubble_xm, ctrl_MULT, ctrl_DIV, md_capture, md_exc_out, md_timeout}
  logic [9:0] outs;
  assign outs = {stall_pc, stall_fd, stall_dx, bubble_dx, bubble_xm,
                 ctrl_MULT, ctrl_DIV, md_capture, md_exc_out, md_timeout};

  localparam logic [9:0] NONE   = 10'b0000000000;
  localparam logic [9:0] LU     = 10'b1101000000;
  localparam logic [9:0] STMUL  = 10'b1110110000;
  localparam logic [9:0] STDIV  = 10'b1110101000;
  localparam logic [9:0] BUSYP  = 10'b1110100000;
  localparam logic [9:0] CAP    = 10'b0000000100;
  localparam logic [9:0] CAPEXC = 10'b0000000110;
  localparam logic [9:0] CAPTO  = 10'b0000000101;

  hazard_stall_control #(
    .MD_TIMEOUT(40),
    .CNT_W(6),
    .STAT_W(16)
  ) dut (
    .clock(clock),
    .reset(reset),
    .rs_fd(rs_fd),
    .rt_fd(rt_fd),
    .rd_fd(rd_fd),
    .fd_uses_rs(fd_uses_rs),
    .fd_uses_rt(fd_uses_rt),
    .fd_uses_rd(fd_uses_rd),
    .fd_is_bex(fd_is_bex),
    .rd_dx(rd_dx),
    .dx_is_lw(dx_is_lw),
    .dx_is_mul(dx_is_mul),
    .dx_is_div(dx_is_div),
    .md_ready(md_ready),
    .md_exception(md_exception),
    .stall_pc(stall_pc),
    .stall_fd(stall_fd),
    .stall_dx(stall_dx),
    .bubble_dx(bubble_dx),
    .bubble_xm(bubble_xm),
    .ctrl_MULT(ctrl_MULT),
    .ctrl_DIV(ctrl_DIV),
    .md_capture(md_capture),
    .md_exc_out(md_exc_out),
    .md_timeout(md_timeout)
`ifdef HAZARD_STALL_STATS_EN
    ,
    .loaduse_cnt(loaduse_cnt),
    .mdbusy_cnt(mdbusy_cnt)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic idleInputs();
    rs_fd = '0; rt_fd = '0; rd_fd = '0; rd_dx = '0;
    fd_uses_rs = 1'b0; fd_uses_rt = 1'b0; fd_uses_rd = 1'b0; fd_is_bex = 1'b0;
    dx_is_lw = 1'b0; dx_is_mul = 1'b0; dx_is_div = 1'b0;
    md_ready = 1'b0; md_exception = 1'b0;
  endtask

  // Inputs change just after a falling edge; outputs are checked 1 time unit later.
  initial begin
    reset = 1'b0;
    idleInputs();
    dx_is_mul = 1'b1; dx_is_lw = 1'b1; rd_dx = 5'd5; rs_fd = 5'd5; fd_uses_rs = 1'b1;
    @(negedge clock); #1 checkVal("reset_outs", {22'd0, outs}, {22'd0, NONE});
    @(negedge clock); reset = 1'b1; idleInputs();
    #1 checkVal("idle_after_reset", {22'd0, outs}, {22'd0, NONE});

    // lw r5 / add reads rs=5
    @(negedge clock); dx_is_lw = 1'b1; rd_dx = 5'd5; rs_fd = 5'd5; fd_uses_rs = 1'b1;
    #1 checkVal("lu_rs", {22'd0, outs}, {22'd0, LU});
    @(negedge clock); idleInputs();
    #1 checkVal("lu_rs_one_cycle", {22'd0, outs}, {22'd0, NONE});
    // r0 destination never stalls
    @(negedge clock); dx_is_lw = 1'b1; rd_dx = 5'd0; rs_fd = 5'd0; fd_uses_rs = 1'b1;
    #1 checkVal("lu_r0", {22'd0, outs}, {22'd0, NONE});
    // rt match only counts when rt is read
    @(negedge clock); idleInputs(); dx_is_lw = 1'b1; rd_dx = 5'd9; rt_fd = 5'd9;
    #1 checkVal("lu_rt_unused", {22'd0, outs}, {22'd0, NONE});
    @(negedge clock); fd_uses_rt = 1'b1;
    #1 checkVal("lu_rt", {22'd0, outs}, {22'd0, LU});
    // bex reads r30
    @(negedge clock); idleInputs(); dx_is_lw = 1'b1; rd_dx = 5'd30; fd_is_bex = 1'b1;
    #1 checkVal("lu_bex", {22'd0, outs}, {22'd0, LU});
    @(negedge clock); rd_dx = 5'd29;
    #1 checkVal("lu_bex_r29", {22'd0, outs}, {22'd0, NONE});
    // sw reads rd
    @(negedge clock); idleInputs(); dx_is_lw = 1'b1; rd_dx = 5'd4; rd_fd = 5'd4; fd_uses_rd = 1'b1;
    #1 checkVal("lu_sw_rd", {22'd0, outs}, {22'd0, LU});
    // no lw in DX -> no stall
    @(negedge clock); dx_is_lw = 1'b0;
    #1 checkVal("no_lw", {22'd0, outs}, {22'd0, NONE});

    // mul, ready on 5th BUSY cycle with exception; load-use masked while busy
    @(negedge clock); idleInputs(); dx_is_mul = 1'b1;
    #1 checkVal("mul_start", {22'd0, outs}, {22'd0, STMUL});
    for (int i = 1; i <= 5; i++) begin
      @(negedge clock);
      md_ready = (i == 5); md_exception = (i == 5);
      dx_is_lw = (i == 3); rd_dx = 5'd5; rs_fd = 5'd5; fd_uses_rs = 1'b1;
      #1 checkVal("mul_busy", {22'd0, outs}, {22'd0, BUSYP});
    end
    @(negedge clock); md_ready = 1'b0; md_exception = 1'b0; dx_is_lw = 1'b0;
    #1 checkVal("mul_capture_exc", {22'd0, outs}, {22'd0, CAPEXC});
    @(negedge clock); idleInputs();
    #1 checkVal("mul_back_idle", {22'd0, outs}, {22'd0, NONE});

    // div never ready -> exactly 40 BUSY cycles then timeout
    @(negedge clock); dx_is_div = 1'b1;
    #1 checkVal("div_start", {22'd0, outs}, {22'd0, STDIV});
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      #1 checkVal("div_busy", {22'd0, outs}, {22'd0, BUSYP});
    end
    @(negedge clock);
    #1 checkVal("div_timeout_capture", {22'd0, outs}, {22'd0, CAPTO});
    @(negedge clock); idleInputs();
    #1 checkVal("div_back_idle", {22'd0, outs}, {22'd0, NONE});

    // ready on the last timeout cycle -> ready wins
    @(negedge clock); dx_is_div = 1'b1;
    #1 checkVal("edge_start", {22'd0, outs}, {22'd0, STDIV});
    for (int i = 1; i <= 40; i++) begin
      @(negedge clock); md_ready = (i == 40);
      #1 checkVal("edge_busy", {22'd0, outs}, {22'd0, BUSYP});
    end
    @(negedge clock); md_ready = 1'b0;
    #1 checkVal("edge_ready_wins", {22'd0, outs}, {22'd0, CAP});

    // mul and div both set: MULT wins
    @(negedge clock); idleInputs(); dx_is_mul = 1'b1; dx_is_div = 1'b1;
    #1 checkVal("both_start", {22'd0, outs}, {22'd0, STMUL});
    @(negedge clock); md_ready = 1'b1;
    #1 checkVal("both_busy", {22'd0, outs}, {22'd0, BUSYP});
    @(negedge clock); md_ready = 1'b0;
    #1 checkVal("both_capture", {22'd0, outs}, {22'd0, CAP});

    // md_ready in IDLE is ignored
    @(negedge clock); idleInputs(); md_ready = 1'b1; md_exception = 1'b1;
    #1 checkVal("ready_in_idle", {22'd0, outs}, {22'd0, NONE});
    @(negedge clock); md_ready = 1'b0; md_exception = 1'b0;
    #1 checkVal("ready_in_idle_next", {22'd0, outs}, {22'd0, NONE});

    // reset mid-BUSY
    @(negedge clock); dx_is_mul = 1'b1;
    #1 checkVal("rst_mul_start", {22'd0, outs}, {22'd0, STMUL});
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      #1 checkVal("rst_mul_busy", {22'd0, outs}, {22'd0, BUSYP});
    end
    #1 reset = 1'b0;
    #1 checkVal("rst_mid_busy", {22'd0, outs}, {22'd0, NONE});
    @(negedge clock); reset = 1'b1;
    #1 checkVal("rst_release_idle", {22'd0, outs}, {22'd0, STMUL});
    @(negedge clock); md_ready = 1'b1;
    #1 checkVal("rst_restart_busy", {22'd0, outs}, {22'd0, BUSYP});
    @(negedge clock); md_ready = 1'b0;
    #1 checkVal("rst_restart_capture", {22'd0, outs}, {22'd0, CAP});
    @(negedge clock); idleInputs();

`ifdef HAZARD_STALL_STATS_EN
    @(negedge clock); reset = 1'b0;
    @(negedge clock); reset = 1'b1;
    #1 checkVal("stats_reset", {loaduse_cnt, mdbusy_cnt}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock); dx_is_lw = 1'b1; rd_dx = 5'd7; rs_fd = 5'd7; fd_uses_rs = 1'b1;
      @(negedge clock); idleInputs();
    end
    @(negedge clock); dx_is_mul = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      @(negedge clock); md_ready = (i == 7);
    end
    @(negedge clock); md_ready = 1'b0;
    @(negedge clock); idleInputs();
    #1 checkVal("stats_loaduse", {16'd0, loaduse_cnt}, 32'd3);
    checkVal("stats_mdbusy", {16'd0, mdbusy_cnt}, 32'd7);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
